// File: rtl/vector_fifo.sv
// Multi-lane synchronous FIFO: all lanes share pointers and occupancy, with threshold flags and flush.
// Optional sticky overflow/underflow ports are enabled by defining VECTOR_FIFO_ERR_FLAGS_EN.
module vector_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ARRAY_SIZE = 3,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             wr_en,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] din,
  output logic                             full,
  output logic                             almost_full,
  input  logic                             rd_en,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] dout,
  output logic                             dout_valid,
  output logic                             empty,
  output logic                             almost_empty,
  output logic [CW-1:0]                    count
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
  ,
  output logic                             overflow,
  output logic                             underflow
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;

  logic [VW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_almost_full;
  logic          r_empty;
  logic          r_almost_empty;
  logic [VW-1:0] r_dout;
  logic          r_dout_valid;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_count_nxt;
  logic [VW-1:0] w_rd_raw;
  logic [VW-1:0] w_rd_scrub;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_rd_raw = r_mem[r_rd_ptr];

  // Occupancy target for this edge; reset and flush both return to an empty FIFO.
  always_comb begin
    w_count_nxt = r_count;
    if (reset || flush) begin
      w_count_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Unknown storage bits never escape onto dout.
  always_comb begin
    w_rd_scrub = '0;
    for (int b = 0; b < int'(VW); b++) begin
      w_rd_scrub[b] = (w_rd_raw[b] === 1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_acc && !reset && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and flags; flags are registered from the next occupancy.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
    r_count        <= w_count_nxt;
    r_full         <= (w_count_nxt == CW'(DEPTH));
    r_empty        <= (w_count_nxt == '0);
    r_almost_full  <= (32'(w_count_nxt) >= AF_LEVEL);
    r_almost_empty <= (32'(w_count_nxt) <= AE_LEVEL);
  end

  // Flush keeps the last popped word visible; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (flush) begin
      r_dout_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_dout       <= w_rd_scrub;
      r_dout_valid <= 1'b1;
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;

`ifdef VECTOR_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky illegal-request flags, cleared only by reset or flush.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full)  r_overflow  <= 1'b1;
      if (rd_en && r_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_vector_fifo.sv
// Directed self-checking bench for vector_fifo (DEPTH=8, 3 lanes, AF=6, AE=2).
module tb_vector_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned NL = 3;
  localparam int unsigned DP = 8;
  localparam int unsigned VW = NL * DW;
  localparam int unsigned CW = $clog2(DP + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [VW-1:0] din   = '0;
  logic [VW-1:0] dout;
  logic          full, almost_full, empty, almost_empty, dout_valid;
  logic [CW-1:0] count;
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vector_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DP), .ARRAY_SIZE(NL), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .empty(empty), .almost_empty(almost_empty), .count(count)
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  // Vector {n, -n, 100+n}; lane 0 in the low bits.
  function automatic logic [VW-1:0] vec(input int n);
    int a, b, c;
    a = n;
    b = -n;
    c = 100 + n;
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_ae", 128'(almost_empty), 128'(1));
    chk("rst_af", 128'(almost_full), 128'(0));
    chk("rst_dout", 128'(dout), 128'(0));
    chk("rst_valid", 128'(dout_valid), 128'(0));
`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_unf", 128'(underflow), 128'(0));
`endif

    // Fill with thresholds observed per write.
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1'b1;
      din   = vec(k);
      step();
      chk("fill_count", 128'(count), 128'(k));
      chk("fill_full", 128'(full), 128'(k == 8));
      chk("fill_ae", 128'(almost_empty), 128'(k <= 2));
      chk("fill_af", 128'(almost_full), 128'(k >= 6));
      chk("fill_empty", 128'(empty), 128'(0));
    end
    wr_en = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      rd_en = 1'b1;
      step();
      chk("drain_valid", 128'(dout_valid), 128'(1));
      chk("drain_dout", 128'(dout), 128'(vec(k)));
      chk("drain_count", 128'(count), 128'(8 - k));
      chk("drain_empty", 128'(empty), 128'(k == 8));
    end
    rd_en = 1'b0;
    step();
    chk("idle_valid", 128'(dout_valid), 128'(0));
    chk("idle_hold", 128'(dout), 128'(vec(8)));

    // Concurrent write+read while empty: only the write lands.
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = vec(50);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("emp_both_count", 128'(count), 128'(1));
    chk("emp_both_valid", 128'(dout_valid), 128'(0));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("emp_both_dout", 128'(dout), 128'(vec(50)));
    chk("emp_both_empty", 128'(empty), 128'(1));

    // Concurrent write+read while full: only the read lands.
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1'b1;
      din   = vec(200 + k);
      step();
    end
    chk("full2_full", 128'(full), 128'(1));
    rd_en = 1'b1;
    din   = vec(999);
    step();
    wr_en = 1'b0;
    chk("full_both_count", 128'(count), 128'(7));
    chk("full_both_valid", 128'(dout_valid), 128'(1));
    chk("full_both_dout", 128'(dout), 128'(vec(201)));
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("full_rest_dout", 128'(dout), 128'(vec(200 + k)));
    end
    rd_en = 1'b0;
    step();
    chk("full_rest_empty", 128'(empty), 128'(1));

    // Steady-state write+read at count 4 across pointer wrap.
    for (int j = 0; j < 4; j++) begin
      wr_en = 1'b1;
      din   = vec(300 + j);
      step();
    end
    rd_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      din = vec(304 + j);
      step();
      chk("wrap_dout", 128'(dout), 128'(vec(300 + j)));
      chk("wrap_count", 128'(count), 128'(4));
    end
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("wrap_tail", 128'(dout), 128'(vec(320 + j)));
    end
    rd_en = 1'b0;
    step();
    chk("wrap_empty", 128'(empty), 128'(1));

    // Flush at count 5 with a concurrent write.
    for (int j = 0; j < 5; j++) begin
      wr_en = 1'b1;
      din   = vec(400 + j);
      step();
    end
    chk("pre_flush_count", 128'(count), 128'(5));
    flush = 1'b1;
    din   = vec(999);
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_empty", 128'(empty), 128'(1));
    chk("flush_ae", 128'(almost_empty), 128'(1));
    chk("flush_dout_hold", 128'(dout), 128'(vec(323)));
    chk("flush_valid", 128'(dout_valid), 128'(0));
    wr_en = 1'b1;
    din   = vec(500);
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_flush_dout", 128'(dout), 128'(vec(500)));
    chk("post_flush_count", 128'(count), 128'(0));

    // Reset mid-stream clears dout as well as occupancy.
    wr_en = 1'b1;
    din   = vec(600);
    step();
    din   = vec(601);
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pre_rst_dout", 128'(dout), 128'(vec(600)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_dout", 128'(dout), 128'(0));
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_empty", 128'(empty), 128'(1));
    wr_en = 1'b1;
    din   = vec(700);
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_rst_dout", 128'(dout), 128'(vec(700)));

`ifdef VECTOR_FIFO_ERR_FLAGS_EN
    // Sticky error flags.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_set", 128'(underflow), 128'(1));
    chk("unf_no_ovf", 128'(overflow), 128'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("unf_clr", 128'(underflow), 128'(0));
    for (int k = 1; k <= 8; k++) begin
      wr_en = 1'b1;
      din   = vec(800 + k);
      step();
    end
    chk("ovf_quiet", 128'(overflow), 128'(0));
    din = vec(999);
    step();
    wr_en = 1'b0;
    chk("ovf_set", 128'(overflow), 128'(1));
    chk("ovf_count", 128'(count), 128'(8));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ovf_sticky", 128'(overflow), 128'(1));
    chk("ovf_dout", 128'(dout), 128'(vec(801)));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ovf_clr", 128'(overflow), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
